mult_issue_taint1bit: RTL and testbench
=======================================

# mult_issue_taint1bit

Upstream issue stage for the 1-bit taint-tracked sequential multiplier. Accepts operand pairs over a valid/ready handshake, registers them with their taint bits, pulses the multiplier's start, waits for its done flag, and returns the product and its taint over a second valid/ready handshake. A watchdog bounds each job. Every control and data signal carries a 1-bit `_t` shadow under the same taint rules as the multiplier.

## Interface
- `WIDTH`, 1024, operand width; product is 2*WIDTH.
- `TIMEOUT`, 4*WIDTH, max BUSY cycles before a job is aborted.
- `CNT_W`, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid`, `in_valid_t` in 1: operand request and its taint.
- `in_ready`, `in_ready_t` out 1: stage can accept.
- `in_multiplier`, `in_multiplicand` in WIDTH: operands.
- `in_multiplier_t`, `in_multiplicand_t` in 1: operand taints.
- `mul_start`, `mul_start_t` out 1: start pulse to the multiplier.
- `mul_multiplier`, `mul_multiplicand` out WIDTH: held operands.
- `mul_multiplier_t`, `mul_multiplicand_t` out 1: held operand taints.
- `mul_product` in 2*WIDTH: multiplier result.
- `mul_product_t` in 1: multiplier result taint.
- `mul_done`, `mul_done_t` in 1: multiplier done flag.
- `out_valid`, `out_valid_t` out 1: result available.
- `out_ready`, `out_ready_t` in 1: consumer accepts.
- `out_product` out 2*WIDTH: result.
- `out_product_t` out 1: result taint.
- `out_error`, `out_error_t` out 1: job aborted by the watchdog.

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch operands and operand taints, go to START.
- START: `mul_start`=1 for exactly one cycle. Always go to BUSY next.
- BUSY: operands held stable.
  - Watchdog counts up from 0 each cycle.
  - `mul_done`=1: capture `mul_product` and `mul_product_t`, clear `out_error`, go to DONE.
  - Counter reaches TIMEOUT-1 without `mul_done`: capture product 0, set `out_error`=1, go to DONE.
  - `mul_done` is sampled only in BUSY. Ignore it in IDLE, START and DONE.
- DONE: `out_valid`=1 and result held. On `out_ready`, go to IDLE.
- No overlap: exactly one job in flight. `in_ready`=0 outside IDLE.
- Control taint bit `st_t`:
  - Loads `in_valid_t` on accept.
  - ORs in `mul_done_t` at the BUSY exit cycle.
  - ORs in `out_ready_t` at the DONE exit cycle.
  - Held otherwise. In IDLE it keeps the previous job's value.
- Output taints:
  - `in_ready_t`, `mul_start_t`, `out_valid_t` and `out_error_t` all equal `st_t`.
  - `mul_*_t` = latched operand taint OR `st_t`.
  - `out_product_t` = captured `mul_product_t` OR `st_t`.
  - `out_product_t` = `st_t` alone on a timeout.

## Timing
- Reset: while `rst`=1 at a clock edge, the following are cleared:
  - state to IDLE, counter to 0, all data and taint registers to 0;
  - `in_ready` is forced 0 while `rst` is high;
  - all other outputs are 0.
- The first accept is possible on the first edge after `rst` deasserts.
- Accept at edge N. `mul_start` is high in cycle N+1. BUSY starts at N+2.
- `mul_done` seen at edge M gives `out_valid`=1 from cycle M+1.
- Output handshake at edge K gives `in_ready`=1 in cycle K+1.
- Minimum round trip: 4 cycles plus the multiplier latency.
- Timeout: `out_valid` asserts exactly TIMEOUT cycles after BUSY entry.
- `mul_done` and the timeout in the same cycle: `mul_done` wins, `out_error`=0.
- `rst` mid-job: abort immediately, with no `out_valid` for that job. The multiplier is reset by the same `rst`.
- Back-pressure: DONE may hold indefinitely. Result and taints are stable while `out_valid` && !`out_ready`.
- Counter saturates, never wraps. It is cleared on BUSY entry.

## Structure
- Shared package `mult_issue_pkg`:
  - state encoding localparams (IDLE=0, START=1, BUSY=2, DONE=3);
  - the default TIMEOUT factor.
- One sub-module `mult_issue_watchdog`:
  - counter and taint-free timeout compare;
  - inputs clear, enable; output expired.
- FSM, operand registers, result registers and taint logic stay in the top module.

## Test plan
Bench uses WIDTH=8, TIMEOUT=32 and a behavioural multiplier with configurable done latency.

- Untainted job, 13×11, latency 9: `mul_start` pulses once at N+1; `out_product`=143; all `_t`=0; `out_error`=0.
- `in_multiplicand_t`=1 on 200×3: `mul_multiplicand_t`=1; `out_product`=600; `out_product_t`=1 only if the model propagates taint; `out_valid_t`=0.
- `in_valid_t`=1 on 5×5: `st_t`=1, so `mul_start_t`, `out_valid_t` and `out_product_t` are all 1. `in_ready_t` stays 1 in the following IDLE.
- Done suppressed: `out_valid` exactly 32 cycles after BUSY entry, with `out_error`=1 and `out_product`=0. Done and timeout in the same cycle gives `out_error`=0.
- `out_ready` low for 20 cycles: result stable; `in_valid` held high is not accepted until the cycle after the handshake.
- `rst` pulsed during BUSY: next cycle state IDLE; all outputs and taints 0 (`in_ready`=1 after deassert); no stale `out_valid`.

Source files
------------

// File: rtl/mult_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_issue_pkg
// Purpose  : State encoding and default watchdog scaling for the issue stage.
// Revision : 1.0 - initial release
// ============================================================================
package mult_issue_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Watchdog budget is this many cycles per operand bit.
    localparam int c_TIMEOUT_FACTOR = 4;

endpackage : mult_issue_pkg
`default_nettype wire

// File: rtl/mult_issue_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mult_issue_watchdog
// Purpose  : Saturating BUSY-cycle counter with a taint-free expiry compare.
// Revision : 1.0 - initial release
// ============================================================================
module mult_issue_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count equals the index of the current BUSY cycle, so the last allowed
    // cycle is TIMEOUT-1.
    assign expired = enable && (r_count >= c_LAST);

endmodule : mult_issue_watchdog
`default_nettype wire

// File: rtl/mult_issue_taint1bit.sv
`default_nettype none
// ============================================================================
// Module   : mult_issue_taint1bit
// Purpose  : Issue stage for the taint-tracked sequential multiplier: accept,
//            start, wait for done (or watchdog), return product with taint.
// Revision : 1.0 - initial release
// ============================================================================
module mult_issue_taint1bit
    import mult_issue_pkg::*;
#(
    parameter int WIDTH   = 1024,
    parameter int TIMEOUT = c_TIMEOUT_FACTOR * WIDTH,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               in_valid,
    input  logic               in_valid_t,
    output logic               in_ready,
    output logic               in_ready_t,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [WIDTH-1:0]   in_multiplicand,
    input  logic               in_multiplier_t,
    input  logic               in_multiplicand_t,

    output logic               mul_start,
    output logic               mul_start_t,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic               mul_multiplier_t,
    output logic               mul_multiplicand_t,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_product_t,
    input  logic               mul_done,
    input  logic               mul_done_t,

    output logic               out_valid,
    output logic               out_valid_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_product_t,
    output logic               out_error,
    output logic               out_error_t
);

    logic [1:0]         r_state;
    logic               r_st_t;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_mplier_t;
    logic               r_mcand_t;
    logic [2*WIDTH-1:0] r_product;
    logic               r_product_t;
    logic               r_error;

    logic               w_wd_clear;
    logic               w_wd_enable;
    logic               w_expired;

    assign w_wd_clear  = (r_state == c_ST_START);
    assign w_wd_enable = (r_state == c_ST_BUSY);

    mult_issue_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_st_t      <= 1'b0;
            r_mplier    <= '0;
            r_mcand     <= '0;
            r_mplier_t  <= 1'b0;
            r_mcand_t   <= 1'b0;
            r_product   <= '0;
            r_product_t <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_mplier   <= in_multiplier;
                        r_mcand    <= in_multiplicand;
                        r_mplier_t <= in_multiplier_t;
                        r_mcand_t  <= in_multiplicand_t;
                        r_st_t     <= in_valid_t;
                        r_state    <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_state <= c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (mul_done) begin
                        r_product   <= mul_product;
                        r_product_t <= mul_product_t;
                        r_error     <= 1'b0;
                        r_st_t      <= r_st_t | mul_done_t;
                        r_state     <= c_ST_DONE;
                    end else if (w_expired) begin
                        r_product   <= '0;
                        r_product_t <= 1'b0;
                        r_error     <= 1'b1;
                        r_st_t      <= r_st_t | mul_done_t;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_st_t  <= r_st_t | out_ready_t;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready           = (r_state == c_ST_IDLE) && !rst;
    assign in_ready_t         = r_st_t;
    assign mul_start          = (r_state == c_ST_START);
    assign mul_start_t        = r_st_t;
    assign mul_multiplier     = r_mplier;
    assign mul_multiplicand   = r_mcand;
    assign mul_multiplier_t   = r_mplier_t | r_st_t;
    assign mul_multiplicand_t = r_mcand_t | r_st_t;
    assign out_valid          = (r_state == c_ST_DONE);
    assign out_valid_t        = r_st_t;
    assign out_product        = r_product;
    assign out_product_t      = r_product_t | r_st_t;
    assign out_error          = r_error;
    assign out_error_t        = r_st_t;

endmodule : mult_issue_taint1bit
`default_nettype wire

// File: tb/tb_mult_issue_taint1bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_issue_taint1bit
// Purpose  : Directed and randomized jobs against a job-level reference model,
//            with a behavioural multiplier of programmable done latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_issue_taint1bit;

    localparam int W = 8;
    localparam int T = 32;

    logic           clk;
    logic           rst;
    logic           in_valid, in_valid_t, in_ready, in_ready_t;
    logic [W-1:0]   in_multiplier, in_multiplicand;
    logic           in_multiplier_t, in_multiplicand_t;
    logic           mul_start, mul_start_t;
    logic [W-1:0]   mul_multiplier, mul_multiplicand;
    logic           mul_multiplier_t, mul_multiplicand_t;
    logic [2*W-1:0] mul_product;
    logic           mul_product_t, mul_done, mul_done_t;
    logic           out_valid, out_valid_t, out_ready, out_ready_t;
    logic [2*W-1:0] out_product;
    logic           out_product_t, out_error, out_error_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   mul_lat = 1;
    logic noise   = 1'b0;
    logic st_m    = 1'b0;

    mult_issue_taint1bit #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
        .in_multiplier_t(in_multiplier_t), .in_multiplicand_t(in_multiplicand_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier_t(mul_multiplier_t), .mul_multiplicand_t(mul_multiplicand_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .out_product(out_product), .out_product_t(out_product_t),
        .out_error(out_error), .out_error_t(out_error_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Behavioural multiplier: done rises mul_lat cycles after the start cycle.
    initial begin
        int   t;
        logic armed;
        t = 0;
        armed = 1'b0;
        mul_done = 1'b0;
        mul_product = '0;
        mul_product_t = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 1'b0;
                t = 0;
            end else if (mul_start) begin
                armed = 1'b1;
                t = 0;
                mul_product   = 16'(mul_multiplier) * 16'(mul_multiplicand);
                mul_product_t = mul_multiplier_t | mul_multiplicand_t;
            end else if (armed) begin
                t++;
            end
            if (armed && t == mul_lat) begin
                mul_done = 1'b1;
                armed = 1'b0;
            end else begin
                mul_done = noise && !armed && ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle before the edge; returns in the cycle after the
    // output handshake.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ta, input logic tb, input logic tv,
                           input int lat, input logic dt, input logic rt,
                           input int hold, input logic keep);
        int             exp_wait, n, extra, unstable, bad;
        logic           exp_err, st1, st2, exp_pt;
        logic [2*W-1:0] exp_p;

        chk("idle_ready", 64'(in_ready), 64'(1));
        chk("idle_ready_t", 64'(in_ready_t), 64'(st_m));
        in_valid = 1'b1;  in_valid_t = tv;
        in_multiplier = a;  in_multiplicand = b;
        in_multiplier_t = ta;  in_multiplicand_t = tb;
        mul_lat = lat;  mul_done_t = dt;
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_valid_t = 1'b0;
        end

        st1 = tv;
        chk("start", 64'(mul_start), 64'(1));
        chk("start_t", 64'(mul_start_t), 64'(st1));
        chk("busy_in_ready", 64'(in_ready), 64'(0));
        chk("mul_multiplier", 64'(mul_multiplier), 64'(a));
        chk("mul_multiplicand", 64'(mul_multiplicand), 64'(b));
        chk("mul_multiplier_t", 64'(mul_multiplier_t), 64'(ta | st1));
        chk("mul_multiplicand_t", 64'(mul_multiplicand_t), 64'(tb | st1));

        exp_err  = (lat > T);
        exp_wait = 1 + (exp_err ? T : lat);
        n = 0;  extra = 0;  unstable = 0;
        do begin
            @(negedge clk);
            n++;
            if (mul_start) extra++;
            if (in_ready !== 1'b0 || mul_multiplier !== a || mul_multiplicand !== b) unstable++;
        end while (!out_valid && n < exp_wait + 8);
        chk("latency", 64'(n), 64'(exp_wait));
        chk("single_start", 64'(extra), 64'(0));
        chk("busy_hold", 64'(unstable), 64'(0));

        st2    = st1 | dt;
        exp_p  = exp_err ? '0 : 16'(a) * 16'(b);
        exp_pt = exp_err ? st2 : (ta | tb | st2);
        chk("out_product", 64'(out_product), 64'(exp_p));
        chk("out_product_t", 64'(out_product_t), 64'(exp_pt));
        chk("out_error", 64'(out_error), 64'(exp_err));
        chk("out_error_t", 64'(out_error_t), 64'(st2));
        chk("out_valid_t", 64'(out_valid_t), 64'(st2));

        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_product !== exp_p || out_error !== exp_err ||
                out_product_t !== exp_pt || in_ready !== 1'b0 || mul_start !== 1'b0) bad++;
        end
        chk("backpressure_hold", 64'(bad), 64'(0));

        out_ready = 1'b1;  out_ready_t = rt;
        @(negedge clk);
        out_ready = 1'b0;  out_ready_t = 1'b0;
        st_m = st2 | rt;
        chk("post_in_ready", 64'(in_ready), 64'(1));
        chk("post_out_valid", 64'(out_valid), 64'(0));
        chk("post_in_ready_t", 64'(in_ready_t), 64'(st_m));
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        in_valid = 1'b0;  in_valid_t = 1'b0;
        in_multiplier = '0;  in_multiplicand = '0;
        in_multiplier_t = 1'b0;  in_multiplicand_t = 1'b0;
        mul_done_t = 1'b0;  out_ready = 1'b0;  out_ready_t = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mul_start", 64'(mul_start), 64'(0));
        chk("rst_out_error", 64'(out_error), 64'(0));
        chk("rst_out_product", 64'(out_product), 64'(0));
        chk("rst_in_ready_t", 64'(in_ready_t), 64'(0));
        chk("rst_mul_multiplier", 64'(mul_multiplier), 64'(0));
        rst = 1'b0;
        #1;

        // Directed jobs from the feature list.
        run_job(8'd13,  8'd11, 1'b0, 1'b0, 1'b0,   9, 1'b0, 1'b0,  0, 1'b0);
        run_job(8'd200, 8'd3,  1'b0, 1'b1, 1'b0,   9, 1'b0, 1'b0,  0, 1'b0);
        run_job(8'd5,   8'd5,  1'b0, 1'b0, 1'b1,   4, 1'b0, 1'b0,  0, 1'b0);
        run_job(8'd7,   8'd9,  1'b0, 1'b0, 1'b0, 200, 1'b0, 1'b0,  0, 1'b0);
        run_job(8'd6,   8'd7,  1'b0, 1'b0, 1'b0,   T, 1'b0, 1'b0,  0, 1'b0);
        run_job(8'd21,  8'd4,  1'b1, 1'b0, 1'b0,   3, 1'b0, 1'b1, 20, 1'b1);
        run_job(8'd2,   8'd3,  1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b0,  2, 1'b0);

        // Randomized jobs with stray done pulses outside BUSY.
        noise = 1'b1;
        for (int j = 0; j < 30; j++) begin
            run_job(W'($urandom), W'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(1, T + 2)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 5)), 1'b0);
        end
        noise = 1'b0;

        // Reset in the middle of a tainted job.
        in_valid = 1'b1;  in_valid_t = 1'b1;
        in_multiplier = 8'd9;  in_multiplicand = 8'd9;
        mul_lat = 20;  mul_done_t = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;  in_valid_t = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_mul_start", 64'(mul_start), 64'(0));
        chk("midrst_start_t", 64'(mul_start_t), 64'(0));
        chk("midrst_in_ready_t", 64'(in_ready_t), 64'(0));
        chk("midrst_mul_mplier_t", 64'(mul_multiplier_t), 64'(0));
        chk("midrst_out_product_t", 64'(out_product_t), 64'(0));
        chk("midrst_out_error", 64'(out_error), 64'(0));
        chk("midrst_mul_mplier", 64'(mul_multiplier), 64'(0));
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(in_ready), 64'(1));
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) cnt++;
        end
        chk("midrst_no_stale_valid", 64'(cnt), 64'(0));
        st_m = 1'b0;

        run_job(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_mult_issue_taint1bit
`default_nettype wire
